// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS core execution units.
//   OP_*      : multiply/divide operation encodings, taken from Funct[1:0]
//               (bit 1 = divide, bit 0 = unsigned)
//   state_t   : sequencing states of the iterative multiply/divide unit
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// Combinational single-step datapath of the iterative multiply/divide unit.
// Operates on magnitudes only; sign handling lives in muldiv_unit.
//   acc_i  [2W] : multiply -> {partial product, remaining multiplier bits}
//                 divide   -> {partial remainder, remaining dividend/quotient}
//   opnd_i [W]  : multiplicand (multiply) or divisor (divide)
//   div_i       : 1 = restoring-divide step, 0 = shift/add multiply step
//   acc_o  [2W] : accumulator after one step
// -----------------------------------------------------------------------------
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   opnd_i,
   input  logic               div_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   always_comb begin
      // Multiply: add the multiplicand into the upper half when the current
      // multiplier bit (LSB) is set, then shift the whole pair right by one.
      // The carry out of the add becomes the new MSB.
      sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
             + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});

      // Divide: bring the next dividend bit into the remainder. The remainder
      // is always below the divisor, so the shifted value fits in WIDTH+1
      // bits and the trial difference, when non-negative, fits in WIDTH.
      rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      diff   = rem_sh - {1'b0, opnd_i};

      acc_o  = {sum, acc_i[WIDTH-1:1]};
      if (div_i) begin
         if (!diff[WIDTH]) begin
            acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers, sitting
// beside the EX-stage ALU. One WIDTH-step pass per operation (CALC) followed
// by a sign fix-up and HI/LO write (FIX).
//   clk             : clock, rising edge
//   reset           : asynchronous, active-low
//   Start, Op[1:0]  : issue an operation (Op[1]=divide, Op[0]=unsigned)
//   A, B            : rs/rt operands; for divide A=dividend, B=divisor
//   MfHi, MfLo      : EX instruction reads HI/LO this cycle
//   MtHi, MtLo      : write A into HI/LO this cycle (IDLE only)
//   Busy            : operation in flight
//   Stall           : hold EX and earlier while busy and HI/LO is touched
//   HI, LO          : architectural result registers
// -----------------------------------------------------------------------------
module muldiv_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             MfHi,
   input  logic             MfLo,
   input  logic             MtHi,
   input  logic             MtLo,
   output logic             Busy,
   output logic             Stall,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d, acc_step;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 div_q, div_d;
   logic                 neg_lo_q, neg_lo_d;   // product / quotient sign
   logic                 neg_hi_q, neg_hi_d;   // remainder sign

   logic                 op_signed, op_div;
   logic                 sign_a, sign_b;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc_i  (acc_q),
      .opnd_i (opnd_q),
      .div_i  (div_q),
      .acc_o  (acc_step)
   );

   // Operand decode and magnitude conversion at issue, sign fix-up at FIX.
   // The most negative value maps to itself, which is its correct unsigned
   // magnitude, so 0x8000_0000 / -1 needs no special case.
   always_comb begin
      op_signed = (Op == OP_MULT) || (Op == OP_DIV);
      op_div    = (Op == OP_DIV)  || (Op == OP_DIVU);
      sign_a    = op_signed & A[WIDTH-1];
      sign_b    = op_signed & B[WIDTH-1];
      mag_a     = sign_a ? (~A + 1'b1) : A;
      mag_b     = sign_b ? (~B + 1'b1) : B;
      prod_fix  = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
      quo_fix   = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      rem_fix   = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                           : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      div_d    = div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;

      unique case (state_q)
         IDLE: begin
            if (Start) begin
               div_d    = op_div;
               opnd_d   = mag_b;
               cnt_d    = CW'(WIDTH - 1);
               neg_lo_d = sign_a ^ sign_b;
               neg_hi_d = op_div & sign_a;
               if (op_div && (B == '0)) begin
                  // Divide by zero: preload the fixed result and let FIX
                  // write it unchanged (LO = all ones, HI = raw dividend).
                  acc_d    = {A, {WIDTH{1'b1}}};
                  neg_lo_d = 1'b0;
                  neg_hi_d = 1'b0;
                  state_d  = FIX;
               end else begin
                  acc_d    = {{WIDTH{1'b0}}, mag_a};
                  state_d  = CALC;
               end
            end else begin
               if (MtHi) hi_d = A;
               if (MtLo) lo_d = A;
            end
         end
         CALC: begin
            acc_d = acc_step;
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         FIX: begin
            if (div_q) begin
               lo_d = quo_fix;
               hi_d = rem_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         div_q    <= div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
      end
   end

   assign Busy  = (state_q != IDLE);
   assign Stall = Busy & (Start | MfHi | MfLo | MtHi | MtLo);
   assign HI    = hi_q;
   assign LO    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit: arithmetic vectors, divide by
// zero, HI/LO moves, stall behaviour, back-to-back issue and async reset.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

   logic        clk, reset, Start, MfHi, MfLo, MtHi, MtLo;
   logic [1:0]  Op;
   logic [31:0] A, B;
   logic        Busy, Stall;
   logic [31:0] HI, LO;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
      .MfHi(MfHi), .MfLo(MfLo), .MtHi(MtHi), .MtLo(MtLo),
      .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and wait (bounded) for Busy to fall; returns the
   // number of cycles Busy was high.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int cyc);
      Start = 1'b1; Op = op; A = a; B = b;
      tick();
      Start = 1'b0; A = '0; B = '0;
      cyc = 0;
      while (Busy && cyc < 100) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; Start = 0; Op = 0; A = 0; B = 0;
      MfHi = 0; MfLo = 0; MtHi = 0; MtLo = 0;
      #1;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", Busy); end
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", Stall); end
      checks++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h exp 0", HI); end
      checks++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h exp 0", LO); end
      tick(); tick();
      #2 reset = 1'b1;
      tick();
   endtask

   task automatic test_mult;
      int cyc;
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL mult_busy_cycles: got %0d exp 33", cyc); end
      checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h exp ffffffff", HI); end
      checks++; if (LO !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h exp ffffffeb", LO); end
      // -5 * -4 = 20
      run_op(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFC, cyc);
      checks++; if ({HI, LO} !== 64'd20) begin errors++; $display("FAIL mult_negneg: got %h_%h exp 0_14", HI, LO); end
   endtask

   task automatic test_multu;
      int cyc;
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
      checks++; if (HI !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h exp fffffffe", HI); end
      checks++; if (LO !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h exp 00000001", LO); end
   endtask

   task automatic test_div;
      int cyc;
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL div_busy_cycles: got %0d exp 33", cyc); end
      checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h exp fffffffd", LO); end
      checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h exp ffffffff", HI); end
      // 7 / -2 = -3 rem 1 (remainder follows dividend sign)
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, cyc);
      checks++; if ({HI, LO} !== {32'd1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_pos_neg: got %h_%h exp 00000001_fffffffd", HI, LO); end
      // Overflow case
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
      checks++; if ({HI, LO} !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL div_overflow: got %h_%h exp 00000000_80000000", HI, LO); end
      // DIVU 100 / 7 = 14 rem 2
      run_op(2'b11, 32'd100, 32'd7, cyc);
      checks++; if ({HI, LO} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_basic: got %h_%h exp 00000002_0000000e", HI, LO); end
      // DIVU with top bit set: 0xFFFFFFFF / 0x10 = 0x0FFFFFFF rem 0xF
      run_op(2'b11, 32'hFFFF_FFFF, 32'h10, cyc);
      checks++; if ({HI, LO} !== {32'hF, 32'h0FFF_FFFF}) begin errors++; $display("FAIL divu_large: got %h_%h exp 0000000f_0fffffff", HI, LO); end
   endtask

   task automatic test_div_by_zero;
      int cyc;
      run_op(2'b11, 32'd100, 32'd0, cyc);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL dz_busy_cycles: got %0d exp 1", cyc); end
      checks++; if (LO !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo: got %h exp ffffffff", LO); end
      checks++; if (HI !== 32'd100) begin errors++; $display("FAIL dz_hi: got %h exp 00000064", HI); end
      // Signed divide by zero keeps the raw (negative) dividend in HI
      run_op(2'b10, 32'hFFFF_FFF9, 32'd0, cyc);
      checks++; if ({HI, LO} !== {32'hFFFF_FFF9, 32'hFFFF_FFFF}) begin errors++; $display("FAIL dz_signed: got %h_%h exp fffffff9_ffffffff", HI, LO); end
   endtask

   task automatic test_move;
      int cyc;
      MtHi = 1'b1; A = 32'd5;
      tick();
      MtHi = 1'b0;
      checks++; if (HI !== 32'd5) begin errors++; $display("FAIL mthi: got %h exp 00000005", HI); end
      MtLo = 1'b1; A = 32'd9;
      tick();
      MtLo = 1'b0; A = '0;
      checks++; if ({HI, LO} !== {32'd5, 32'd9}) begin errors++; $display("FAIL mtlo: got %h_%h exp 00000005_00000009", HI, LO); end
      MfHi = 1'b1; #1;
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL mf_idle_stall: got %b exp 0", Stall); end
      MfHi = 1'b0;
      // Start and MtHi together: Start wins
      Start = 1'b1; Op = 2'b01; A = 32'd2; B = 32'd3; MtHi = 1'b1;
      tick();
      Start = 1'b0; MtHi = 1'b0; A = '0; B = '0;
      checks++; if (HI !== 32'd5) begin errors++; $display("FAIL start_beats_mt: got %h exp 00000005", HI); end
      cyc = 0;
      while (Busy && cyc < 100) begin tick(); cyc++; end
      checks++; if ({HI, LO} !== {32'd0, 32'd6}) begin errors++; $display("FAIL start_beats_mt_res: got %h_%h exp 00000000_00000006", HI, LO); end
   endtask

   task automatic test_stall;
      int cyc;
      bit stall_bad;
      Start = 1'b1; Op = 2'b00; A = 32'd5; B = 32'd6;
      tick();
      Start = 1'b0; A = '0; B = '0;
      repeat (4) tick();
      // Second Start while busy: stalls and must be ignored
      Start = 1'b1; Op = 2'b11; A = 32'd9; B = 32'd3; #1;
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL start_busy_stall: got %b exp 1", Stall); end
      tick();
      Start = 1'b0; A = '0; B = '0;
      repeat (4) tick();
      MfLo = 1'b1; #1;
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL mflo_busy_stall: got %b exp 1", Stall); end
      stall_bad = 1'b0;
      cyc = 0;
      while (Busy && cyc < 100) begin
         if (Stall !== 1'b1) stall_bad = 1'b1;
         tick();
         cyc++;
      end
      checks++; if (stall_bad !== 1'b0) begin errors++; $display("FAIL mflo_stall_held: got drop=%b exp 0", stall_bad); end
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL mflo_stall_release: got %b exp 0", Stall); end
      checks++; if ({HI, LO} !== {32'd0, 32'd30}) begin errors++; $display("FAIL stall_result: got %h_%h exp 00000000_0000001e", HI, LO); end
      MfLo = 1'b0;
      tick();
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ignored_start: got busy %b exp 0", Busy); end
   endtask

   task automatic test_back_to_back;
      int cyc;
      run_op(2'b01, 32'd3, 32'd4, cyc);
      checks++; if ({HI, LO} !== {32'd0, 32'd12}) begin errors++; $display("FAIL b2b_first: got %h_%h exp 00000000_0000000c", HI, LO); end
      // Issued in the very first IDLE cycle after FIX
      Start = 1'b1; Op = 2'b11; A = 32'd100; B = 32'd7; #1;
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b exp 0", Stall); end
      Start = 1'b0;
      run_op(2'b11, 32'd100, 32'd7, cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_busy_cycles: got %0d exp 33", cyc); end
      checks++; if ({HI, LO} !== {32'd2, 32'd14}) begin errors++; $display("FAIL b2b_second: got %h_%h exp 00000002_0000000e", HI, LO); end
   endtask

   task automatic test_reset_mid_op;
      int cyc;
      MtHi = 1'b1; MtLo = 1'b1; A = 32'h1234;
      tick();
      MtHi = 1'b0; MtLo = 1'b0;
      Start = 1'b1; Op = 2'b10; A = 32'hFFFF_FFF9; B = 32'd2;
      tick();
      Start = 1'b0; A = '0; B = '0;
      repeat (14) tick();
      MfHi = 1'b1; #1;
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b exp 1", Stall); end
      reset = 1'b0; #1;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b exp 0", Busy); end
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL midreset_stall: got %b exp 0", Stall); end
      checks++; if ({HI, LO} !== 64'h0) begin errors++; $display("FAIL midreset_hilo: got %h_%h exp 0_0", HI, LO); end
      MfHi = 1'b0;
      #1 reset = 1'b1;
      tick();
      run_op(2'b01, 32'd6, 32'd7, cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL post_reset_cycles: got %0d exp 33", cyc); end
      checks++; if ({HI, LO} !== {32'd0, 32'd42}) begin errors++; $display("FAIL post_reset_multu: got %h_%h exp 00000000_0000002a", HI, LO); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_div_by_zero();
      test_move();
      test_stall();
      test_back_to_back();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
